// File: rtl/ddr_local_pkg.sv
// ddr_local_pkg: shared widths and request bundle for the DDR2 local-interface responder
package ddr_local_pkg;
    localparam int LOCAL_AW = 23;
    localparam int LOCAL_DW = 64;
    typedef struct packed {
        logic [LOCAL_AW-1:0] addr;
        logic [LOCAL_DW-1:0] wdata;
        logic                rd;
        logic                wr;
    } local_req_t;
endpackage

// File: rtl/ddr_rd_lat_pipe.sv
// ddr_rd_lat_pipe: read valid/address delay line with a fetch tap one stage before the end
module ddr_rd_lat_pipe #(
    parameter int RD_LAT = 4,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    output logic          tap_valid,
    output logic [AW-1:0] tap_addr,
    output logic          out_valid
);
    logic [RD_LAT-1:0] v;
    logic [AW-1:0]     a [RD_LAT-1];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) v <= '0;
        else v <= {v[RD_LAT-2:0], in_valid};
    // addresses need no reset: they are only observed through the valid bits
    always_ff @(posedge clk) begin
        a[0] <= in_addr;
        for (int i = 1; i < RD_LAT - 1; i++) a[i] <= a[i-1];
    end
    assign tap_valid = v[RD_LAT-2];
    assign tap_addr  = a[RD_LAT-2];
    assign out_valid = v[RD_LAT-1];
endmodule

// File: rtl/ddr_local_responder.sv
// ddr_local_responder: on-chip RAM stand-in for a DDR2 controller local interface,
// emulating init delay, refresh backpressure and fixed read latency
module ddr_local_responder import ddr_local_pkg::*; #(
    parameter int INIT_CYCLES    = 64,
    parameter int RD_LAT         = 4,
    parameter int MEM_AW         = 8,
    parameter int REFRESH_PERIOD = 1024,
    parameter int REFRESH_LEN    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [LOCAL_AW-1:0] local_address,
    input  logic                local_read_req,
    input  logic                local_write_req,
    input  logic [LOCAL_DW-1:0] local_wdata,
    output logic                local_ready,
    output logic [LOCAL_DW-1:0] local_rdata,
    output logic                local_rdata_valid,
    output logic                local_init_done,
    output logic                err_req_conflict,
    output logic [15:0]         wr_count,
    output logic [15:0]         rd_count
);
    localparam int RW = $clog2(REFRESH_PERIOD);
    localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_PERIOD - 1);
    localparam logic [RW-1:0] REF_LEN   = RW'(REFRESH_LEN);
    localparam logic [15:0]   INIT_LAST = 16'(INIT_CYCLES - 1);

    local_req_t          req;
    logic [MEM_AW-1:0]   addr;
    logic                unused_addr;
    logic                acc_wr, acc_rd;
    logic [15:0]         init_cnt;
    logic [RW-1:0]       ref_cnt, ref_nxt;
    logic                tap_valid, out_valid;
    logic [MEM_AW-1:0]   tap_addr;
    logic [LOCAL_DW-1:0] ram_q;
    logic [LOCAL_DW-1:0] mem [2**MEM_AW];

    assign req         = '{addr: local_address, wdata: local_wdata, rd: local_read_req, wr: local_write_req};
    assign addr        = req.addr[MEM_AW-1:0];
    assign unused_addr = ^req.addr[LOCAL_AW-1:MEM_AW];
    // a simultaneous read is dropped in favour of the write
    assign acc_wr      = req.wr & local_ready;
    assign acc_rd      = req.rd & ~req.wr & local_ready;
    assign ref_nxt     = (ref_cnt == REF_LAST) ? '0 : ref_cnt + 1'b1;

    ddr_rd_lat_pipe #(.RD_LAT(RD_LAT), .AW(MEM_AW)) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (acc_rd),
        .in_addr   (addr),
        .tap_valid (tap_valid),
        .tap_addr  (tap_addr),
        .out_valid (out_valid)
    );

    // write-first: a write landing on the fetched address this cycle wins
    always_ff @(posedge clk) begin
        if (acc_wr) mem[addr] <= req.wdata;
        if (tap_valid) ram_q <= (acc_wr && addr == tap_addr) ? req.wdata : mem[tap_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt          <= '0;
            local_init_done   <= 1'b0;
            ref_cnt           <= '0;
            local_ready       <= 1'b0;
            err_req_conflict  <= 1'b0;
            wr_count          <= '0;
            rd_count          <= '0;
            local_rdata       <= '0;
            local_rdata_valid <= 1'b0;
        end else begin
            if (!local_init_done) begin
                init_cnt        <= init_cnt + 1'b1;
                local_init_done <= init_cnt == INIT_LAST;
            end else begin
                ref_cnt     <= ref_nxt;
                local_ready <= ref_nxt >= REF_LEN;
            end
            if (acc_wr) wr_count <= wr_count + 1'b1;
            if (acc_rd) rd_count <= rd_count + 1'b1;
            if (req.rd & req.wr & local_ready) err_req_conflict <= 1'b1;
            local_rdata_valid <= out_valid;
            if (out_valid) local_rdata <= ram_q;
        end
    end
endmodule

// File: tb/tb_ddr_local_responder.sv
// tb_ddr_local_responder: directed and random traffic against a cycle-numbered reference model
module tb_ddr_local_responder;
    localparam int INIT = 64, RD_LAT = 4, PERIOD = 1024, LEN = 8;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [22:0] local_address = '0;
    logic        local_read_req = 1'b0, local_write_req = 1'b0;
    logic [63:0] local_wdata = '0;
    logic        local_ready, local_rdata_valid, local_init_done, err_req_conflict;
    logic [63:0] local_rdata;
    logic [15:0] wr_count, rd_count;

    ddr_local_responder #(
        .INIT_CYCLES(INIT), .RD_LAT(RD_LAT), .MEM_AW(8),
        .REFRESH_PERIOD(PERIOD), .REFRESH_LEN(LEN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .local_address(local_address),
        .local_read_req(local_read_req), .local_write_req(local_write_req),
        .local_wdata(local_wdata), .local_ready(local_ready), .local_rdata(local_rdata),
        .local_rdata_valid(local_rdata_valid), .local_init_done(local_init_done),
        .err_req_conflict(err_req_conflict), .wr_count(wr_count), .rd_count(rd_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        int          fetch;
        int          out;
        logic [63:0] d;
        bit          k;
    } rd_t;

    int          n_cmp = 0, n_err = 0;
    int          t = 0;
    bit          acc;
    rd_t         pend[$];
    logic [63:0] mm [256];
    bit          mk [256];
    logic [15:0] m_wc = 0, m_rc = 0;
    bit          m_err = 0, e_valid = 0, m_rk = 1;
    logic [63:0] m_rdata = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0d: got %h expected %h", tag, t, got, exp);
        end
    endtask

    function automatic bit m_ready(int e);
        return e >= INIT && ((e - INIT) % PERIOD) >= LEN;
    endfunction

    function automatic void m_reset();
        t = 0; pend.delete(); m_wc = 0; m_rc = 0; m_err = 0;
        e_valid = 0; m_rdata = 0; m_rk = 1;
    endfunction

    // reads see every write accepted up to and including their fetch edge
    function automatic void model_edge();
        bit rdy;
        logic [7:0] a;
        if (!rst_n) return;
        rdy = m_ready(t);
        t++;
        a = local_address[7:0];
        acc = rdy && (local_read_req || local_write_req);
        if (rdy && local_write_req) begin mm[a] = local_wdata; mk[a] = 1; m_wc++; end
        if (rdy && local_read_req && local_write_req) m_err = 1;
        if (rdy && local_read_req && !local_write_req) begin
            m_rc++;
            pend.push_back('{a: a, fetch: t + RD_LAT - 1, out: t + RD_LAT, d: 64'h0, k: 1'b0});
        end
        foreach (pend[i]) if (pend[i].fetch == t) begin
            pend[i].d = mm[pend[i].a];
            pend[i].k = mk[pend[i].a];
        end
        e_valid = 0;
        if (pend.size() > 0 && pend[0].out == t) begin
            e_valid = 1; m_rdata = pend[0].d; m_rk = pend[0].k;
            void'(pend.pop_front());
        end
    endfunction

    task automatic compare();
        check("ready", local_ready, m_ready(t));
        check("init_done", local_init_done, t >= INIT);
        check("rdata_valid", local_rdata_valid, e_valid);
        if (m_rk) check("rdata", local_rdata, m_rdata);
        check("wr_count", wr_count, m_wc);
        check("rd_count", rd_count, m_rc);
        check("err_conflict", err_req_conflict, m_err);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic idle(int n);
        local_read_req = 0; local_write_req = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // initiator holds the request until the model says it was accepted
    task automatic do_req(bit rd, bit wr, logic [22:0] a, logic [63:0] d);
        int n = 0;
        local_read_req = rd; local_write_req = wr; local_address = a; local_wdata = d;
        do begin tick(); n++; end while (!acc && n < 2000);
        if (!acc) check("req_timeout", 0, 1);
        local_read_req = 0; local_write_req = 0;
    endtask

    initial begin
        int n;
        foreach (mk[i]) begin mk[i] = 0; mm[i] = '0; end
        #3;
        compare();
        repeat (2) tick();
        rst_n = 1;
        m_reset();
        idle(INIT + LEN + 2);

        for (int i = 0; i < 256; i++) do_req(0, 1, 23'h1000 + 23'(i), 64'h0101_0000_0000_0000 + 64'(23'h1000 + 23'(i)));
        for (int i = 0; i < 256; i++) do_req(1, 0, 23'h1000 + 23'(i), 64'h0);
        idle(RD_LAT + 2);
        check("burst_wr_count", wr_count, 16'd256);
        check("burst_rd_count", rd_count, 16'd256);

        do_req(0, 1, 23'd5, 64'hDEAD_BEEF_0000_0001);
        do_req(1, 0, 23'd5, 64'h0);
        do_req(1, 0, 23'd7, 64'h0);
        idle(1);
        do_req(0, 1, 23'd7, 64'h77);
        idle(RD_LAT + 2);

        do_req(1, 1, 23'h000003, 64'hC0FF_EE00_1234_5678);
        idle(RD_LAT + 2);
        do_req(1, 0, 23'h100003, 64'h0);
        idle(RD_LAT + 2);

        n = 0;
        while (((t - INIT) % PERIOD) != PERIOD - 4 && n < 3000) begin tick(); n++; end
        for (int i = 0; i < 12; i++) do_req(0, 1, 23'h20 + 23'(i), {$urandom, $urandom});
        for (int i = 0; i < 12; i++) do_req(1, 0, 23'h20 + 23'(i), 64'h0);
        idle(RD_LAT + 2);

        for (int i = 0; i < 3000; i++) begin
            int r = $urandom_range(0, 9);
            local_read_req  = r < 4;
            local_write_req = r >= 3 && r < 7;
            local_address   = {15'($urandom), 4'h0, 4'($urandom)};
            local_wdata     = {$urandom, $urandom};
            tick();
        end
        idle(RD_LAT + 2);

        for (int i = 0; i < 3; i++) begin
            local_read_req = 1; local_address = 23'(i);
            tick();
        end
        idle(1);
        rst_n = 0;
        #1;
        m_reset();
        compare();
        idle(2);
        rst_n = 1;
        idle(INIT + LEN + 4);
        do_req(0, 1, 23'h42, 64'h1234_5678_9ABC_DEF0);
        do_req(1, 0, 23'h42, 64'h0);
        idle(RD_LAT + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
